// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Round sequencer for an iterative AES datapath. A block is accepted in IDLE,
// the state register is loaded with Data_In XOR the first round key (LOAD),
// NR-1 full rounds run with MixColumns enabled (ROUND), one last round runs
// with MixColumns bypassed (FINAL), and the result is held until the consumer
// takes it (HOLD). Any round waits while the requested key is not yet valid.
//
// Parameters
//   NR          number of AES rounds: 10, 12 or 14
//
// Optional build macro
//   AES_DECRYPT_EN  adds the Mode input (1 = decrypt); key indices then run
//                   from NR down to 0 instead of 0 up to NR
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   Mode       in   1 = decrypt, sampled on accept (AES_DECRYPT_EN only)
//   In_Valid   in   new block present at the datapath input
//   In_Ready   out  controller can accept a block (IDLE and no Flush)
//   Out_Valid  out  state register holds a finished result
//   Out_Ready  in   consumer takes the result
//   Key_Valid  in   round key selected by Key_Idx is available
//   Flush      in   synchronous abort, returns to IDLE on the next edge
//   Ld_State   out  load state register with Data_In XOR first round key
//   Rnd_En     out  state register captures the round datapath output
//   Mix_En     out  1 = MixColumns path, 0 = bypass
//   Key_Idx    out  round-key index requested from key storage
//   Round_Cnt  out  current round number, 0..NR
//   Busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef AES_DECRYPT_EN
    input  logic       Mode,
`endif
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    input  logic       Key_Valid,
    input  logic       Flush,
    output logic       Ld_State,
    output logic       Rnd_En,
    output logic       Mix_En,
    output logic [3:0] Key_Idx,
    output logic [3:0] Round_Cnt,
    output logic       Busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] NR_C         = 4'(NR);
    localparam logic [3:0] LAST_ROUND_C = 4'(NR - 1);

    state_t     state_r;
    state_t     state_next_s;
    state_t     trans_state_s;
    logic [3:0] round_cnt_r;
    logic [3:0] cnt_next_s;
    logic [3:0] trans_cnt_s;
    logic       accept_s;
    logic       mode_next_s;

    logic       ld_state_r;
    logic       mix_en_r;
    logic [3:0] key_idx_r;
    logic       out_valid_r;
    logic       busy_r;

    logic       ld_next_s;
    logic       mix_next_s;
    logic [3:0] key_idx_next_s;
    logic       out_valid_next_s;
    logic       busy_next_s;

    // Key index requested for a given state/round. Decrypt walks the key
    // schedule backwards: NR at load, NR-round inside the rounds, 0 at the end.
    function automatic logic [3:0] key_idx_f(input state_t st,
                                             input logic [3:0] cnt,
                                             input logic dec);
        logic [3:0] idx;
        case (st)
            ST_LOAD:  idx = dec ? NR_C : 4'd0;
            ST_ROUND: idx = dec ? (NR_C - cnt) : cnt;
            ST_FINAL: idx = dec ? 4'd0 : NR_C;
            default:  idx = 4'd0;
        endcase
        return idx;
    endfunction

    // In_Ready and Rnd_En must react to Flush / Key_Valid within the cycle,
    // so they are decoded from the registered state without a pipeline stage.
    assign In_Ready = (state_r == ST_IDLE) && !Flush;
    assign accept_s = In_Valid && In_Ready;
    assign Rnd_En   = ((state_r == ST_ROUND) || (state_r == ST_FINAL)) && Key_Valid;

`ifdef AES_DECRYPT_EN
    logic mode_r;

    // Direction is captured on accept and stays fixed for the whole block.
    always_comb begin
        if (accept_s) begin
            mode_next_s = Mode;
        end else begin
            mode_next_s = mode_r;
        end
    end

    // Operation direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 1'b0;
        end else begin
            mode_r <= mode_next_s;
        end
    end
`else
    assign mode_next_s = 1'b0;
`endif

    // Transition logic; the counter only advances on a valid key and stops at NR.
    always_comb begin
        trans_state_s = state_r;
        trans_cnt_s   = round_cnt_r;
        case (state_r)
            ST_IDLE: begin
                trans_cnt_s = 4'd0;
                if (accept_s) begin
                    trans_state_s = ST_LOAD;
                end else begin
                    trans_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                trans_state_s = ST_ROUND;
                trans_cnt_s   = 4'd1;
            end
            ST_ROUND: begin
                if (Key_Valid) begin
                    if (round_cnt_r >= LAST_ROUND_C) begin
                        trans_state_s = ST_FINAL;
                        trans_cnt_s   = NR_C;
                    end else begin
                        trans_state_s = ST_ROUND;
                        trans_cnt_s   = round_cnt_r + 4'd1;
                    end
                end else begin
                    trans_state_s = ST_ROUND;
                    trans_cnt_s   = round_cnt_r;
                end
            end
            ST_FINAL: begin
                trans_cnt_s = NR_C;
                if (Key_Valid) begin
                    trans_state_s = ST_HOLD;
                end else begin
                    trans_state_s = ST_FINAL;
                end
            end
            ST_HOLD: begin
                if (Out_Ready) begin
                    trans_state_s = ST_IDLE;
                    trans_cnt_s   = 4'd0;
                end else begin
                    trans_state_s = ST_HOLD;
                    trans_cnt_s   = NR_C;
                end
            end
            default: begin
                trans_state_s = ST_IDLE;
                trans_cnt_s   = 4'd0;
            end
        endcase
    end

    // Flush overrides every transition, including accept and Out_Ready.
    always_comb begin
        if (Flush) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = 4'd0;
        end else begin
            state_next_s = trans_state_s;
            cnt_next_s   = trans_cnt_s;
        end
    end

    // Output values for the upcoming state, registered alongside it so the
    // outputs change on the same edge as the state without glitches.
    always_comb begin
        ld_next_s        = (state_next_s == ST_LOAD);
        mix_next_s       = (state_next_s == ST_ROUND);
        out_valid_next_s = (state_next_s == ST_HOLD);
        busy_next_s      = (state_next_s != ST_IDLE);
        key_idx_next_s   = key_idx_f(state_next_s, cnt_next_s, mode_next_s);
    end

    // FSM state and round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            round_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_next_s;
            round_cnt_r <= cnt_next_s;
        end
    end

    // Registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_r  <= 1'b0;
            mix_en_r    <= 1'b0;
            key_idx_r   <= 4'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ld_state_r  <= ld_next_s;
            mix_en_r    <= mix_next_s;
            key_idx_r   <= key_idx_next_s;
            out_valid_r <= out_valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign Ld_State  = ld_state_r;
    assign Mix_En    = mix_en_r;
    assign Key_Idx   = key_idx_r;
    assign Out_Valid = out_valid_r;
    assign Busy      = busy_r;
    assign Round_Cnt = round_cnt_r;

endmodule
